// File: rtl/mem_port_arbiter_if.sv
// Purpose: bundles the requester (C/D) handshakes, the shared memory port and
// the arbiter status signals used by mem_port_arbiter.
// Signals:
//   c_*/d_*  : request, write flag, address, write data, read data, ack per requester
//   m_*      : shared memory address / write data / write enable / read data
//   busy     : arbiter owns the memory port
//   gnt_id   : granted requester (0 = C, 1 = D), meaningful while busy
// Modports: slave = arbiter side, master = requesters + memory side.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_adr;
  logic [DW-1:0] c_wdata;
  logic [DW-1:0] c_rdata;
  logic          c_ack;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_adr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;

  logic [AW-1:0] m_adr;
  logic [DW-1:0] m_wdata;
  logic          m_we;
  logic [DW-1:0] m_rdata;

  logic          busy;
  logic          gnt_id;

  modport slave (
    input  c_req, c_we, c_adr, c_wdata,
    input  d_req, d_we, d_adr, d_wdata,
    input  m_rdata,
    output c_rdata, c_ack, d_rdata, d_ack,
    output m_adr, m_wdata, m_we,
    output busy, gnt_id
  );

  modport master (
    output c_req, c_we, c_adr, c_wdata,
    output d_req, d_we, d_adr, d_wdata,
    output m_rdata,
    input  c_rdata, c_ack, d_rdata, d_ack,
    input  m_adr, m_wdata, m_we,
    input  busy, gnt_id
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose: shares the single unified memory port between the CPU (C) and the
// DMA/debug loader (D). One transaction at a time, round-robin on ties.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : mem_port_arbiter_if.slave (requester handshakes, memory port, status)
// Parameters: MEM_LAT (1..7) cycles the address is held before m_rdata is
// sampled; AW / DW address and data widths.
//
// state  | meaning
// IDLE   | no transaction; arbitrate between c_req and d_req
// ACCESS | address/data held on the memory port for MEM_LAT cycles
// DONE   | one-cycle ack to the granted requester, update round-robin pointer
module mem_port_arbiter #(
  parameter int MEM_LAT = 1,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  localparam logic [2:0] CNT_INIT = 3'(MEM_LAT - 1);

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          we_q, we_d;
  logic          gnt_q, gnt_d;
  logic          last_q, last_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] c_rdata_q, c_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          win;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      adr_q     <= '0;
      wdata_q   <= '0;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      adr_q     <= adr_d;
      wdata_q   <= wdata_d;
      c_rdata_q <= c_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    adr_d     = adr_q;
    wdata_d   = wdata_q;
    c_rdata_d = c_rdata_q;
    d_rdata_d = d_rdata_q;
    // D wins when alone, or on a tie when C was served last.
    win       = bus.d_req && (!bus.c_req || !last_q);

    case (state_q)
      S_IDLE: begin
        if (bus.c_req || bus.d_req) begin
          gnt_d   = win;
          adr_d   = win ? bus.d_adr   : bus.c_adr;
          wdata_d = win ? bus.d_wdata : bus.c_wdata;
          we_d    = win ? bus.d_we    : bus.c_we;
          cnt_d   = CNT_INIT;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q == 3'd0) begin
          state_d = S_DONE;
          if (!we_q) begin
            if (gnt_q) d_rdata_d = bus.m_rdata;
            else       c_rdata_d = bus.m_rdata;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_DONE: begin
        last_d  = gnt_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Decoded from state so reset drops the write strobe and acks at once.
  // The counter still holds its load value only in the first ACCESS cycle,
  // which gives exactly one write strobe per transaction.
  assign bus.m_we    = (state_q == S_ACCESS) && we_q && (cnt_q == CNT_INIT);
  assign bus.m_adr   = adr_q;
  assign bus.m_wdata = wdata_q;
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.gnt_id  = gnt_q;
  assign bus.c_ack   = (state_q == S_DONE) && !gnt_q;
  assign bus.d_ack   = (state_q == S_DONE) && gnt_q;
  assign bus.c_rdata = c_rdata_q;
  assign bus.d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: self-checking bench for mem_port_arbiter; two instances (MEM_LAT=1
// and MEM_LAT=3), directed scenarios plus a randomized run against a
// transaction-level reference model.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];
  logic [31:0] ref_mem [256];
  logic        rd3_ovr;
  logic [31:0] rd3_val;

  mem_port_arbiter_if bus1 ();
  mem_port_arbiter_if bus3 ();

  mem_port_arbiter #(.MEM_LAT(1)) u1 (.clk(clk), .reset(reset), .bus(bus1.slave));
  mem_port_arbiter #(.MEM_LAT(3)) u3 (.clk(clk), .reset(reset), .bus(bus3.slave));

  always #5 clk = ~clk;

  assign bus1.m_rdata = mem1[bus1.m_adr[9:2]];
  assign bus3.m_rdata = rd3_ovr ? rd3_val : mem3[bus3.m_adr[9:2]];

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus1.m_we === 1'b1) mem1[bus1.m_adr[9:2]] = bus1.m_wdata;
    if (bus3.m_we === 1'b1) mem3[bus3.m_adr[9:2]] = bus3.m_wdata;
  endtask

  task automatic clear_inputs();
    bus1.c_req = 0; bus1.c_we = 0; bus1.c_adr = 0; bus1.c_wdata = 0;
    bus1.d_req = 0; bus1.d_we = 0; bus1.d_adr = 0; bus1.d_wdata = 0;
    bus3.c_req = 0; bus3.c_we = 0; bus3.c_adr = 0; bus3.c_wdata = 0;
    bus3.d_req = 0; bus3.d_we = 0; bus3.d_adr = 0; bus3.d_wdata = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    n_cmp++; if (bus1.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus1.busy); end
    n_cmp++; if (bus1.m_we !== 1'b0) begin n_err++; $display("FAIL reset_m_we: got %b want 0", bus1.m_we); end
    n_cmp++; if (bus1.m_adr !== 32'd0) begin n_err++; $display("FAIL reset_m_adr: got %h want 0", bus1.m_adr); end
    n_cmp++; if (bus1.m_wdata !== 32'd0) begin n_err++; $display("FAIL reset_m_wdata: got %h want 0", bus1.m_wdata); end
    n_cmp++; if ({bus1.c_ack, bus1.d_ack, bus1.gnt_id} !== 3'b000) begin n_err++; $display("FAIL reset_ack_gnt: got %b want 000", {bus1.c_ack, bus1.d_ack, bus1.gnt_id}); end
    n_cmp++; if (bus1.c_rdata !== 32'd0 || bus1.d_rdata !== 32'd0) begin n_err++; $display("FAIL reset_rdata: got %h/%h want 0/0", bus1.c_rdata, bus1.d_rdata); end
    n_cmp++; if (bus3.busy !== 1'b0 || bus3.m_we !== 1'b0) begin n_err++; $display("FAIL reset_lat3: got busy=%b m_we=%b want 0/0", bus3.busy, bus3.m_we); end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_c_read();
    mem1[16] = 32'h8C020044;
    bus1.c_req = 1; bus1.c_we = 0; bus1.c_adr = 32'h40;
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_cmp++; if (bus1.busy !== (k == 1 || k == 2)) begin n_err++; $display("FAIL c_read_busy k=%0d: got %b want %b", k, bus1.busy, (k == 1 || k == 2)); end
      n_cmp++; if (bus1.c_ack !== (k == 2)) begin n_err++; $display("FAIL c_read_ack k=%0d: got %b want %b", k, bus1.c_ack, (k == 2)); end
      n_cmp++; if (bus1.d_ack !== 1'b0) begin n_err++; $display("FAIL c_read_d_ack k=%0d: got %b want 0", k, bus1.d_ack); end
      if (k == 1) begin
        n_cmp++; if (bus1.m_adr !== 32'h40) begin n_err++; $display("FAIL c_read_m_adr: got %h want 00000040", bus1.m_adr); end
      end
      if (k >= 2) begin
        n_cmp++; if (bus1.c_rdata !== 32'h8C020044) begin n_err++; $display("FAIL c_read_rdata k=%0d: got %h want 8c020044", k, bus1.c_rdata); end
      end
      if (k == 2) bus1.c_req = 0;
    end
  endtask

  task automatic test_d_write();
    logic [31:0] c_old, d_old;
    int nwe;
    c_old = bus1.c_rdata;
    d_old = bus1.d_rdata;
    nwe = 0;
    bus1.d_req = 1; bus1.d_we = 1; bus1.d_adr = 32'h80; bus1.d_wdata = 32'hDEADBEEF;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (bus1.m_we === 1'b1) begin
        nwe++;
        n_cmp++; if (bus1.m_adr !== 32'h80 || bus1.m_wdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL d_write_bus: got %h/%h want 00000080/deadbeef", bus1.m_adr, bus1.m_wdata); end
      end
      n_cmp++; if (bus1.d_ack !== (k == 2)) begin n_err++; $display("FAIL d_write_ack k=%0d: got %b want %b", k, bus1.d_ack, (k == 2)); end
      n_cmp++; if (bus1.c_ack !== 1'b0) begin n_err++; $display("FAIL d_write_c_ack k=%0d: got %b want 0", k, bus1.c_ack); end
      n_cmp++; if (bus1.c_rdata !== c_old || bus1.d_rdata !== d_old) begin n_err++; $display("FAIL d_write_rdata k=%0d: got %h/%h want %h/%h", k, bus1.c_rdata, bus1.d_rdata, c_old, d_old); end
      if (k == 1) begin
        n_cmp++; if (bus1.gnt_id !== 1'b1) begin n_err++; $display("FAIL d_write_gnt: got %b want 1", bus1.gnt_id); end
      end
      if (k == 2) bus1.d_req = 0;
    end
    n_cmp++; if (nwe != 1) begin n_err++; $display("FAIL d_write_strobes: got %0d want 1", nwe); end
    n_cmp++; if (mem1[32] !== 32'hDEADBEEF) begin n_err++; $display("FAIL d_write_mem: got %h want deadbeef", mem1[32]); end
  endtask

  // Both held: grants alternate C,D,C,D; with MEM_LAT=1 each slot is 3 cycles.
  task automatic test_back_to_back();
    bit exp_c, exp_d;
    do_reset();
    bus1.c_req = 1; bus1.c_we = 0; bus1.c_adr = 32'h10;
    bus1.d_req = 1; bus1.d_we = 0; bus1.d_adr = 32'h20;
    for (int k = 1; k <= 11; k++) begin
      tick();
      exp_c = (k % 3 == 2) && (((k - 2) / 3) % 2 == 0);
      exp_d = (k % 3 == 2) && (((k - 2) / 3) % 2 == 1);
      n_cmp++; if (bus1.c_ack !== exp_c) begin n_err++; $display("FAIL b2b_c_ack k=%0d: got %b want %b", k, bus1.c_ack, exp_c); end
      n_cmp++; if (bus1.d_ack !== exp_d) begin n_err++; $display("FAIL b2b_d_ack k=%0d: got %b want %b", k, bus1.d_ack, exp_d); end
      if (k % 3 == 1) begin
        n_cmp++; if (bus1.gnt_id !== 1'(((k - 1) / 3) % 2)) begin n_err++; $display("FAIL b2b_gnt k=%0d: got %b want %0d", k, bus1.gnt_id, ((k - 1) / 3) % 2); end
      end
    end
    bus1.c_req = 0; bus1.d_req = 0;
    tick();
    tick();
    n_cmp++; if (bus1.busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle: got busy=%b want 0", bus1.busy); end
  endtask

  // m_rdata changes every cycle; only the value in the last ACCESS cycle may land.
  task automatic test_lat3_read();
    bit exp_busy;
    do_reset();
    rd3_ovr = 1; rd3_val = 32'hBAD00000;
    bus3.d_req = 1; bus3.d_we = 0; bus3.d_adr = 32'h100;
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp_busy = (k >= 1 && k <= 4);
      n_cmp++; if (bus3.busy !== exp_busy) begin n_err++; $display("FAIL lat3_busy k=%0d: got %b want %b", k, bus3.busy, exp_busy); end
      n_cmp++; if (bus3.d_ack !== (k == 4)) begin n_err++; $display("FAIL lat3_ack k=%0d: got %b want %b", k, bus3.d_ack, (k == 4)); end
      if (k <= 3) begin
        n_cmp++; if (bus3.m_adr !== 32'h100) begin n_err++; $display("FAIL lat3_m_adr k=%0d: got %h want 00000100", k, bus3.m_adr); end
      end
      if (k >= 4) begin
        n_cmp++; if (bus3.d_rdata !== 32'h600DCAFE) begin n_err++; $display("FAIL lat3_rdata k=%0d: got %h want 600dcafe", k, bus3.d_rdata); end
      end
      rd3_val = (k == 3) ? 32'h600DCAFE : (32'hBAD00000 + 32'(k));
      if (k == 4) bus3.d_req = 0;
    end
    rd3_ovr = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus3.c_req = 1; bus3.c_we = 1; bus3.c_adr = 32'h20; bus3.c_wdata = 32'hA5A5A5A5;
    tick();
    n_cmp++; if (bus3.m_we !== 1'b1) begin n_err++; $display("FAIL rmid_first_we: got %b want 1", bus3.m_we); end
    tick();
    n_cmp++; if (bus3.busy !== 1'b1) begin n_err++; $display("FAIL rmid_busy_before: got %b want 1", bus3.busy); end
    reset = 1'b1;
    #1;
    n_cmp++; if (bus3.m_we !== 1'b0 || bus3.busy !== 1'b0) begin n_err++; $display("FAIL rmid_async: got m_we=%b busy=%b want 0/0", bus3.m_we, bus3.busy); end
    bus3.c_req = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (bus3.c_ack !== 1'b0) begin n_err++; $display("FAIL rmid_no_ack k=%0d: got %b want 0", k, bus3.c_ack); end
    end
    reset = 1'b0;
    bus3.c_req = 1; bus3.c_we = 0; bus3.c_adr = 32'h24;
    bus3.d_req = 1; bus3.d_we = 0; bus3.d_adr = 32'h28;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) begin
        n_cmp++; if (bus3.gnt_id !== 1'b0 || bus3.busy !== 1'b1) begin n_err++; $display("FAIL rmid_first_gnt: got gnt=%b busy=%b want 0/1", bus3.gnt_id, bus3.busy); end
      end
      n_cmp++; if (bus3.c_ack !== (k == 4)) begin n_err++; $display("FAIL rmid_c_ack k=%0d: got %b want %b", k, bus3.c_ack, (k == 4)); end
    end
    bus3.c_req = 0; bus3.d_req = 0;
    for (int k = 0; k < 6; k++) tick();
  endtask

  task automatic test_drop_mid();
    int nack;
    do_reset();
    mem3[65] = 32'h13579BDF;
    nack = 0;
    bus3.d_req = 1; bus3.d_we = 0; bus3.d_adr = 32'h104;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 1) bus3.d_req = 0;
      if (bus3.d_ack === 1'b1) nack++;
      n_cmp++; if (bus3.d_ack !== (k == 4)) begin n_err++; $display("FAIL drop_ack k=%0d: got %b want %b", k, bus3.d_ack, (k == 4)); end
      n_cmp++; if (bus3.busy !== (k <= 4)) begin n_err++; $display("FAIL drop_busy k=%0d: got %b want %b", k, bus3.busy, (k <= 4)); end
      if (k == 4) begin
        n_cmp++; if (bus3.d_rdata !== 32'h13579BDF) begin n_err++; $display("FAIL drop_rdata: got %h want 13579bdf", bus3.d_rdata); end
      end
    end
    n_cmp++; if (nack != 1) begin n_err++; $display("FAIL drop_ack_count: got %0d want 1", nack); end
  endtask

  // Transaction-level model: a grant happens when the port is free and someone
  // is requesting; the transaction completes MEM_LAT+1 cycles later and the
  // port is free again the cycle after.
  task automatic test_random();
    int grant_cyc, ack_cyc, nxt_idle;
    bit active, last, cur_win, cur_we, cpend, dpend;
    bit exp_busy, exp_cack, exp_dack, exp_mwe;
    logic [31:0] cur_adr, cur_wdata, cur_rd, exp_crd, exp_drd, v;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      mem1[i] = v;
      ref_mem[i] = v;
    end
    active = 0; last = 1; nxt_idle = 0; cpend = 0; dpend = 0;
    grant_cyc = 0; ack_cyc = 0; cur_win = 0; cur_we = 0;
    cur_adr = 0; cur_wdata = 0; cur_rd = 0; exp_crd = 0; exp_drd = 0;
    for (int k = 1; k <= 600; k++) begin
      tick();
      exp_busy = active && (k > grant_cyc) && (k <= ack_cyc);
      exp_cack = active && (k == ack_cyc) && !cur_win;
      exp_dack = active && (k == ack_cyc) && cur_win;
      exp_mwe  = active && (k == grant_cyc + 1) && cur_we;
      if (active && k == ack_cyc && !cur_we) begin
        if (cur_win) exp_drd = cur_rd;
        else         exp_crd = cur_rd;
      end
      n_cmp++; if (bus1.busy !== exp_busy) begin n_err++; $display("FAIL rnd_busy k=%0d: got %b want %b", k, bus1.busy, exp_busy); end
      n_cmp++; if (bus1.c_ack !== exp_cack) begin n_err++; $display("FAIL rnd_c_ack k=%0d: got %b want %b", k, bus1.c_ack, exp_cack); end
      n_cmp++; if (bus1.d_ack !== exp_dack) begin n_err++; $display("FAIL rnd_d_ack k=%0d: got %b want %b", k, bus1.d_ack, exp_dack); end
      n_cmp++; if (bus1.m_we !== exp_mwe) begin n_err++; $display("FAIL rnd_m_we k=%0d: got %b want %b", k, bus1.m_we, exp_mwe); end
      n_cmp++; if (bus1.c_rdata !== exp_crd) begin n_err++; $display("FAIL rnd_c_rdata k=%0d: got %h want %h", k, bus1.c_rdata, exp_crd); end
      n_cmp++; if (bus1.d_rdata !== exp_drd) begin n_err++; $display("FAIL rnd_d_rdata k=%0d: got %h want %h", k, bus1.d_rdata, exp_drd); end
      if (exp_busy) begin
        n_cmp++; if (bus1.gnt_id !== cur_win || bus1.m_adr !== cur_adr) begin n_err++; $display("FAIL rnd_gnt_adr k=%0d: got %b/%h want %b/%h", k, bus1.gnt_id, bus1.m_adr, cur_win, cur_adr); end
      end
      if (exp_mwe) begin
        n_cmp++; if (bus1.m_wdata !== cur_wdata) begin n_err++; $display("FAIL rnd_m_wdata k=%0d: got %h want %h", k, bus1.m_wdata, cur_wdata); end
      end

      if (active && k == ack_cyc) begin
        active = 0;
        if (cur_win) begin dpend = 0; bus1.d_req = 0; end
        else         begin cpend = 0; bus1.c_req = 0; end
      end else begin
        if (!cpend && $urandom_range(0, 2) == 0) begin
          cpend = 1; bus1.c_req = 1; bus1.c_we = 1'($urandom_range(0, 1));
          bus1.c_adr = {22'd0, 8'($urandom_range(0, 255)), 2'd0}; bus1.c_wdata = $urandom;
        end
        if (!dpend && $urandom_range(0, 2) == 0) begin
          dpend = 1; bus1.d_req = 1; bus1.d_we = 1'($urandom_range(0, 1));
          bus1.d_adr = {22'd0, 8'($urandom_range(0, 255)), 2'd0}; bus1.d_wdata = $urandom;
        end
      end

      if (!active && k >= nxt_idle && (cpend || dpend)) begin
        cur_win   = dpend && (!cpend || !last);
        cur_we    = cur_win ? bus1.d_we    : bus1.c_we;
        cur_adr   = cur_win ? bus1.d_adr   : bus1.c_adr;
        cur_wdata = cur_win ? bus1.d_wdata : bus1.c_wdata;
        if (cur_we) ref_mem[cur_adr[9:2]] = cur_wdata;
        else        cur_rd = ref_mem[cur_adr[9:2]];
        grant_cyc = k;
        ack_cyc   = k + 2;
        nxt_idle  = k + 3;
        last      = cur_win;
        active    = 1;
      end
    end
    bus1.c_req = 0; bus1.d_req = 0;
    for (int k = 0; k < 4; k++) tick();
  endtask

  initial begin
    rd3_ovr = 0;
    rd3_val = 0;
    for (int i = 0; i < 256; i++) begin
      mem1[i] = 0;
      mem3[i] = 0;
      ref_mem[i] = 0;
    end
    clear_inputs();
    reset = 1'b1;
    test_reset();
    test_c_read();
    test_d_write();
    test_back_to_back();
    test_lat3_read();
    test_reset_mid();
    test_drop_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
